// File: rtl/detect_annunciator.sv
// -----------------------------------------------------------------------------
// detect_annunciator
//
// Purpose: counts consecutive TARGET results from a recogniser and raises an
//          audible alert. An alert is a square-wave tone on the piezo output
//          that lasts BEEP_CYCLES clocks. Alerts raised are counted, and the
//          count saturates at 255.
//
// Optional feature: define DETECT_HOLDOFF_EN to add a HOLDOFF lockout of
//          HOLDOFF_CYCLES clocks after each alert. Without the macro, no
//          HOLDOFF state or counter is built.
//
// Ports:
//   clk        system clock (rising edge)
//   reset      asynchronous active-low reset
//   enable     1 = alerts may be armed; 0 = streak held at 0
//   mute       1 = beep held low (state machine unaffected)
//   result_dv  one-cycle strobe, result valid
//   result     recogniser class code [CLASS_W]
//   beep       registered tone to piezo
//   led        last received class code [CLASS_W]
//   busy       registered, high while not ARMED
//   alert_cnt  saturating alert counter [8]
// -----------------------------------------------------------------------------
module detect_annunciator #(
    parameter int unsigned CLASS_W        = 2,
    parameter int unsigned TARGET         = 1,
    parameter int unsigned CONSEC         = 2,
    parameter int unsigned BEEP_CYCLES    = 50000000,
    parameter int unsigned TONE_HALF      = 6250,
    parameter int unsigned HOLDOFF_CYCLES = 25000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               mute,
    input  logic               result_dv,
    input  logic [CLASS_W-1:0] result,
    output logic               beep,
    output logic [CLASS_W-1:0] led,
    output logic               busy,
    output logic [7:0]         alert_cnt
);

    localparam int unsigned STREAK_W = $clog2(CONSEC + 1);
    localparam int unsigned BEEP_W   = $clog2(BEEP_CYCLES + 1);
    localparam int unsigned TONE_W   = $clog2(TONE_HALF + 1);

    // Elaboration-time parameter sanity check.
    if (CONSEC < 1 || BEEP_CYCLES < 1 || TONE_HALF < 1 || HOLDOFF_CYCLES < 1) begin : g_bad_param
        $error("detect_annunciator: CONSEC, BEEP_CYCLES, TONE_HALF and HOLDOFF_CYCLES must be >= 1");
    end

`ifdef DETECT_HOLDOFF_EN
    localparam int unsigned HOLD_W = $clog2(HOLDOFF_CYCLES + 1);
    typedef enum logic [1:0] {
        ST_ARMED   = 2'd0,
        ST_BEEP    = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;
`else
    typedef enum logic {
        ST_ARMED = 1'b0,
        ST_BEEP  = 1'b1
    } state_t;
`endif

    state_t              state;
    state_t              next_state;

    logic [STREAK_W-1:0] streak;
    logic [STREAK_W-1:0] streak_n;
    logic [BEEP_W-1:0]   beep_cnt;
    logic [BEEP_W-1:0]   beep_cnt_n;
    logic [TONE_W-1:0]   tone_cnt;
    logic [TONE_W-1:0]   tone_cnt_n;
    logic                tone;
    logic                tone_n;
    logic                beep_n;
    logic                busy_n;
    logic [CLASS_W-1:0]  led_n;
    logic [7:0]          alert_cnt_n;

    logic                is_target_c;
    logic                fire_c;
    logic                beep_last_c;
    logic                tone_last_c;

`ifdef DETECT_HOLDOFF_EN
    logic [HOLD_W-1:0]   hold_cnt;
    logic [HOLD_W-1:0]   hold_cnt_n;
    logic                hold_last_c;

    assign hold_last_c = (hold_cnt == HOLD_W'(HOLDOFF_CYCLES - 1));
`endif

    // Alert trigger: the result that completes the streak while armed.
    assign is_target_c = (result == CLASS_W'(TARGET));
    assign fire_c      = (state == ST_ARMED) && result_dv && enable && is_target_c
                         && (streak == STREAK_W'(CONSEC - 1));
    assign beep_last_c = (beep_cnt == BEEP_W'(BEEP_CYCLES - 1));
    assign tone_last_c = (tone_cnt == TONE_W'(TONE_HALF - 1));

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_ARMED;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            ST_ARMED: begin
                if (fire_c) begin
                    next_state = ST_BEEP;
                end
            end
            ST_BEEP: begin
                if (beep_last_c) begin
`ifdef DETECT_HOLDOFF_EN
                    next_state = ST_HOLDOFF;
`else
                    next_state = ST_ARMED;
`endif
                end
            end
`ifdef DETECT_HOLDOFF_EN
            ST_HOLDOFF: begin
                if (hold_last_c) begin
                    next_state = ST_ARMED;
                end
            end
`endif
            default: next_state = ST_ARMED;
        endcase
    end

    // Output/datapath logic: next values for counters and registered outputs.
    always_comb begin
        streak_n    = '0;
        beep_cnt_n  = '0;
        tone_cnt_n  = '0;
        tone_n      = 1'b0;
        led_n       = led;
        alert_cnt_n = alert_cnt;
`ifdef DETECT_HOLDOFF_EN
        hold_cnt_n  = '0;
`endif

        if (result_dv) begin
            led_n = result;
        end

        // Streak only advances while armed and enabled; otherwise it stays 0.
        if ((state == ST_ARMED) && enable) begin
            streak_n = streak;
            if (result_dv) begin
                streak_n = (is_target_c && !fire_c) ? streak + STREAK_W'(1) : '0;
            end
        end

        if (fire_c && (alert_cnt != 8'hFF)) begin
            alert_cnt_n = alert_cnt + 8'd1;
        end

        // Counters and tone run only while staying in BEEP, so every entry starts clean.
        if ((state == ST_BEEP) && (next_state == ST_BEEP)) begin
            beep_cnt_n = beep_cnt + BEEP_W'(1);
            if (tone_last_c) begin
                tone_cnt_n = '0;
                tone_n     = ~tone;
            end else begin
                tone_cnt_n = tone_cnt + TONE_W'(1);
                tone_n     = tone;
            end
        end

`ifdef DETECT_HOLDOFF_EN
        if ((state == ST_HOLDOFF) && (next_state == ST_HOLDOFF)) begin
            hold_cnt_n = hold_cnt + HOLD_W'(1);
        end
`endif

        // Registered outputs are computed from next state so they align with it.
        beep_n = (next_state == ST_BEEP) && tone_n && !mute;
        busy_n = (next_state != ST_ARMED);
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            streak    <= '0;
            beep_cnt  <= '0;
            tone_cnt  <= '0;
            tone      <= 1'b0;
            beep      <= 1'b0;
            busy      <= 1'b0;
            led       <= '0;
            alert_cnt <= '0;
        end else begin
            streak    <= streak_n;
            beep_cnt  <= beep_cnt_n;
            tone_cnt  <= tone_cnt_n;
            tone      <= tone_n;
            beep      <= beep_n;
            busy      <= busy_n;
            led       <= led_n;
            alert_cnt <= alert_cnt_n;
        end
    end

`ifdef DETECT_HOLDOFF_EN
    // Holdoff counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_cnt <= '0;
        end else begin
            hold_cnt <= hold_cnt_n;
        end
    end
`endif

endmodule

// File: tb/tb_detect_annunciator.sv
// -----------------------------------------------------------------------------
// tb_detect_annunciator
//
// Purpose: directed self-checking bench for detect_annunciator with
//          CONSEC=2, BEEP_CYCLES=20, TONE_HALF=3, HOLDOFF_CYCLES=10, TARGET=1.
//          Inputs change on the falling edge; outputs are sampled there too.
// Ports:   none (top-level bench).
// -----------------------------------------------------------------------------
module tb_detect_annunciator;

    localparam int unsigned CLASS_W = 2;
    localparam int unsigned BEEP_N  = 20;
    localparam int unsigned TONE_H  = 3;
`ifdef DETECT_HOLDOFF_EN
    localparam int unsigned BUSY_LEN = 30;
`else
    localparam int unsigned BUSY_LEN = 20;
`endif

    logic               clk;
    logic               reset;
    logic               enable;
    logic               mute;
    logic               result_dv;
    logic [CLASS_W-1:0] result;
    logic               beep;
    logic [CLASS_W-1:0] led;
    logic               busy;
    logic [7:0]         alert_cnt;

    int checks;
    int errors;
    int exp_cnt;

    detect_annunciator #(
        .CLASS_W       (CLASS_W),
        .TARGET        (1),
        .CONSEC        (2),
        .BEEP_CYCLES   (BEEP_N),
        .TONE_HALF     (TONE_H),
        .HOLDOFF_CYCLES(10)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .mute     (mute),
        .result_dv(result_dv),
        .result   (result),
        .beep     (beep),
        .led      (led),
        .busy     (busy),
        .alert_cnt(alert_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One result strobe; returns on the falling edge after it was sampled.
    task automatic send(input logic [CLASS_W-1:0] r);
        @(negedge clk);
        result    = r;
        result_dv = 1'b1;
        @(negedge clk);
        result_dv = 1'b0;
    endtask

    task automatic test_reset();
        #3 reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (beep !== 1'b0) begin errors++; $display("FAIL reset_beep: got %b expected 0", beep); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (led !== 2'd0) begin errors++; $display("FAIL reset_led: got %0d expected 0", led); end
        checks++; if (alert_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", alert_cnt); end
        reset = 1'b1;
        exp_cnt = 0;
    endtask

    task automatic test_alert();
        logic exp_beep;
        send(2'd1);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL alert_first_dv_busy: got %b expected 0", busy); end
        send(2'd1);
        exp_cnt++;
        for (int k = 0; k < int'(BUSY_LEN); k++) begin
            exp_beep = (k < int'(BEEP_N)) ? (((k / int'(TONE_H)) % 2) == 1) : 1'b0;
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL alert_busy[%0d]: got %b expected 1", k, busy); end
            checks++; if (beep !== exp_beep) begin errors++; $display("FAIL alert_beep[%0d]: got %b expected %b", k, beep, exp_beep); end
            @(negedge clk);
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL alert_busy_end: got %b expected 0", busy); end
        checks++; if (beep !== 1'b0) begin errors++; $display("FAIL alert_beep_end: got %b expected 0", beep); end
        checks++; if (alert_cnt !== 8'(exp_cnt)) begin errors++; $display("FAIL alert_cnt: got %0d expected %0d", alert_cnt, exp_cnt); end
    endtask

    task automatic test_no_alert();
        send(2'd1);
        send(2'd2);
        checks++; if (led !== 2'd2) begin errors++; $display("FAIL noalert_led2: got %0d expected 2", led); end
        send(2'd1);
        checks++; if (led !== 2'd1) begin errors++; $display("FAIL noalert_led1: got %0d expected 1", led); end
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL noalert_busy: got %b expected 0", busy); end
        checks++; if (alert_cnt !== 8'(exp_cnt)) begin errors++; $display("FAIL noalert_cnt: got %0d expected %0d", alert_cnt, exp_cnt); end
        // Streak is 1 after the trailing 1, so one more 1 completes an alert.
        send(2'd1);
        exp_cnt++;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL noalert_followup_busy: got %b expected 1", busy); end
        repeat (BUSY_LEN) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL noalert_followup_end: got %b expected 0", busy); end
    endtask

    task automatic test_enable();
        enable = 1'b0;
        send(2'd1);
        send(2'd1);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL enable_low_busy: got %b expected 0", busy); end
        checks++; if (led !== 2'd1) begin errors++; $display("FAIL enable_low_led: got %0d expected 1", led); end
        // A streak built while enabled is wiped by a cycle of enable low.
        enable = 1'b1;
        send(2'd1);
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        send(2'd1);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL enable_clear_busy: got %b expected 0", busy); end
        checks++; if (alert_cnt !== 8'(exp_cnt)) begin errors++; $display("FAIL enable_cnt: got %0d expected %0d", alert_cnt, exp_cnt); end
        send(2'd3);
    endtask

    task automatic test_mute();
        mute = 1'b1;
        send(2'd1);
        send(2'd1);
        exp_cnt++;
        for (int k = 0; k < int'(BUSY_LEN); k++) begin
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mute_busy[%0d]: got %b expected 1", k, busy); end
            checks++; if (beep !== 1'b0) begin errors++; $display("FAIL mute_beep[%0d]: got %b expected 0", k, beep); end
            @(negedge clk);
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mute_busy_end: got %b expected 0", busy); end
        checks++; if (alert_cnt !== 8'(exp_cnt)) begin errors++; $display("FAIL mute_cnt: got %0d expected %0d", alert_cnt, exp_cnt); end
        mute = 1'b0;
    endtask

    task automatic test_back_to_back();
        send(2'd1);
        send(2'd1);
        exp_cnt++;
        repeat (2) @(negedge clk);
        send(2'd1);
        send(2'd1);
        repeat (BUSY_LEN - 7) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_last: got %b expected 1", busy); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_end: got %b expected 0", busy); end
        repeat (5) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_no_second: got %b expected 0", busy); end
        checks++; if (alert_cnt !== 8'(exp_cnt)) begin errors++; $display("FAIL b2b_cnt: got %0d expected %0d", alert_cnt, exp_cnt); end
    endtask

    task automatic test_reset_mid_beep();
        send(2'd1);
        send(2'd1);
        repeat (7) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b expected 1", busy); end
        reset = 1'b0;
        #1;
        exp_cnt = 0;
        checks++; if (beep !== 1'b0) begin errors++; $display("FAIL midrst_beep: got %b expected 0", beep); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        checks++; if (alert_cnt !== 8'd0) begin errors++; $display("FAIL midrst_cnt: got %0d expected 0", alert_cnt); end
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++; if ((beep !== 1'b0) || (busy !== 1'b0)) begin errors++; $display("FAIL midrst_residual[%0d]: got beep %b busy %b expected 0 0", k, beep, busy); end
        end
        send(2'd1);
        send(2'd1);
        exp_cnt++;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_new_busy: got %b expected 1", busy); end
        repeat (3) @(negedge clk);
        checks++; if (beep !== 1'b1) begin errors++; $display("FAIL midrst_new_beep3: got %b expected 1", beep); end
        repeat (BUSY_LEN - 3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_new_end: got %b expected 0", busy); end
        checks++; if (alert_cnt !== 8'(exp_cnt)) begin errors++; $display("FAIL midrst_new_cnt: got %0d expected %0d", alert_cnt, exp_cnt); end
    endtask

    task automatic test_saturation();
        int n;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        exp_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            send(2'd1);
            send(2'd1);
            exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
            n = 0;
            while ((busy === 1'b1) && (n < 100)) begin
                @(negedge clk);
                n++;
            end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sat_timeout[%0d]: got busy %b expected 0", i, busy); end
            if (i == 254) begin
                checks++; if (alert_cnt !== 8'd255) begin errors++; $display("FAIL sat_255: got %0d expected 255", alert_cnt); end
            end
        end
        checks++; if (alert_cnt !== 8'(exp_cnt)) begin errors++; $display("FAIL sat_hold: got %0d expected %0d", alert_cnt, exp_cnt); end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        exp_cnt   = 0;
        reset     = 1'b1;
        enable    = 1'b1;
        mute      = 1'b0;
        result_dv = 1'b0;
        result    = '0;
        test_reset();
        test_alert();
        test_no_alert();
        test_enable();
        test_mute();
        test_back_to_back();
        test_reset_mid_beep();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/detect_annunciator.md
DETECT_ANNUNCIATOR -- requirements
Module: detect_annunciator

Interface
REQ-001 Parameter CLASS_W, default 2, width of the recogniser class code.
REQ-002 Parameter TARGET, default 1, class code that counts toward an alert.
REQ-003 Parameter CONSEC, default 2, minimum 1, number of consecutive TARGET results required to raise an alert.
REQ-004 Parameter BEEP_CYCLES, default 50000000, alert duration in clk cycles.
REQ-005 Parameter TONE_HALF, default 6250, tone half-period in clk cycles (4 kHz at 50 MHz).
REQ-006 Parameter HOLDOFF_CYCLES, default 25000000, post-alert lockout in clk cycles (used only with DETECT_HOLDOFF_EN).
REQ-007 clk  in  1  single system clock; all logic on its rising edge.
REQ-008 reset  in  1  asynchronous, active-low reset.
REQ-009 enable  in  1  high = alerts may be armed; low = streak forced to 0.
REQ-010 mute  in  1  high = beep output held 0; state machine runs unchanged.
REQ-011 result_dv  in  1  one-cycle strobe, result valid.
REQ-012 result  in  CLASS_W  recogniser class code.
REQ-013 beep  out  1  registered square-wave tone to piezo.
REQ-014 led  out  CLASS_W  last received class code.
REQ-015 busy  out  1  high while state is not ARMED.
REQ-016 alert_cnt  out  8  saturating count of alerts raised.

Function
REQ-017 The block SHALL implement states ARMED, BEEP and (with macro) HOLDOFF.
REQ-018 In ARMED, on result_dv with enable high: result==TARGET SHALL increment streak; any other result SHALL clear streak.
REQ-019 When result_dv, enable high, result==TARGET and streak==CONSEC-1, the next state SHALL be BEEP, streak SHALL clear to 0, and alert_cnt SHALL increment, saturating at 255.
REQ-020 result_dv in BEEP or HOLDOFF SHALL NOT affect streak; streak SHALL remain 0.
REQ-021 enable low SHALL hold streak at 0 and prevent entry to BEEP; an alert already in BEEP or HOLDOFF SHALL run to completion.
REQ-022 BEEP SHALL last exactly BEEP_CYCLES clk cycles, counted by beep_cnt from 0 to BEEP_CYCLES-1; on the last count the state SHALL leave BEEP.
REQ-023 Tone SHALL start at 0 on BEEP entry and toggle every TONE_HALF cycles while in BEEP.
REQ-024 beep SHALL equal tone AND NOT mute, registered, and SHALL be 0 in every state other than BEEP.
REQ-025 led SHALL load result one cycle after any result_dv, in every state and regardless of enable.
REQ-026 busy SHALL be registered and high in the same cycle that the state is BEEP or HOLDOFF.
REQ-027 Internal counters SHALL be sized to hold their parameter values without wrap.

Reset
REQ-028 reset low SHALL immediately force state ARMED, streak 0, beep_cnt 0, tone 0, beep 0, led 0, busy 0 and alert_cnt 0.
REQ-029 reset asserted mid-BEEP SHALL abort the alert with no residual tone after release.
REQ-030 After reset deassertion, the first result_dv SHALL be processed normally.

Configuration
REQ-031 Macro DETECT_HOLDOFF_EN defined: on BEEP completion the state SHALL enter HOLDOFF for exactly HOLDOFF_CYCLES cycles with busy high, then return to ARMED.
REQ-032 DETECT_HOLDOFF_EN undefined: BEEP completion SHALL return directly to ARMED, and no HOLDOFF state or counter logic SHALL be generated.

Verification (CONSEC=2, BEEP_CYCLES=20, TONE_HALF=3, HOLDOFF_CYCLES=10, TARGET=1)
REQ-033 Results 1,1 with enable=1 -> BEEP entered the cycle after the second dv; beep pattern 0,0,0,1,1,1,... for 20 cycles; alert_cnt=1.
REQ-034 Results 1,2,1 -> no alert; streak is 0 after the 2; led=1 after the last dv.
REQ-035 Results 1,1 with mute=1 -> busy high for 20 cycles, beep stays 0, alert_cnt=1.
REQ-036 Results 1,1 during BEEP -> ignored; no second alert; busy drops after 20 cycles (30 cycles with DETECT_HOLDOFF_EN).
REQ-037 reset low at beep cycle 7 -> beep=0, busy=0 and alert_cnt=0 at once; results 1,1 afterwards -> new alert.
REQ-038 256 alerts -> alert_cnt saturates at 255.
